button_gesture: RTL

//  Consumes the clean level and single-cycle edge pulses produced by the debounce block.

---
 rtl/button_gesture.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/button_gesture.sv
// -----------------------------------------------------------------------------
// button_gesture
//   Turns the debounced button edges into gesture pulses: tap, double_tap,
//   long_press and auto-repeat. All timing is in milliseconds, counted by an
//   internal prescaler (CLK_PER_MS cycles per ms) feeding a saturating ms
//   counter. The ms timer restarts on every state change and on every repeat.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous reset, active low
//   btn_level    debounced level (informational only, not used for decisions)
//   btn_posedge  1-cycle pulse on a debounced rising edge
//   btn_negedge  1-cycle pulse on a debounced falling edge
//   tap          1-cycle pulse: released before LONG_MS
//   double_tap   1-cycle pulse: second tap within DOUBLE_MS, coincident with tap
//   long_press   1-cycle pulse: hold reached LONG_MS
//   repeat_out   1-cycle pulse every REPEAT_MS while held after long_press
//   pressed      level: state is PRESSED or HELD
// -----------------------------------------------------------------------------
module button_gesture #(
    parameter int ACTIVE_LOW = 1,
    parameter int FREQ       = 50,
    parameter int CLK_PER_MS = FREQ * 1000,
    parameter int LONG_MS    = 600,
    parameter int DOUBLE_MS  = 250,
    parameter int REPEAT_MS  = 150,
    parameter int N          = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_level,
    input  logic btn_posedge,
    input  logic btn_negedge,
    output logic tap,
    output logic double_tap,
    output logic long_press,
    output logic repeat_out,
    output logic pressed
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PRESSED = 2'd1;
    localparam logic [1:0] S_HELD    = 2'd2;
    localparam logic [1:0] S_GAP     = 2'd3;

    localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_MS - 1);
    localparam logic [N-1:0]  LONG_N     = N'(LONG_MS);
    localparam logic [N-1:0]  DOUBLE_N   = N'(DOUBLE_MS);
    localparam logic [N-1:0]  REPEAT_N   = N'(REPEAT_MS);
    localparam logic [N-1:0]  MS_MAX     = '1;

    logic [1:0]    state, state_nxt;
    logic          second, second_nxt;
    logic [PW-1:0] presc;
    logic [N-1:0]  ms_cnt;
    logic          tap_nxt, dbl_nxt, lp_nxt, rep_nxt;
    logic          press_raw, rel_raw, press_e, rel_e;
    logic          restart;
    logic          unused_level;

    // Level is only carried for visibility; edges drive every decision.
    assign unused_level = btn_level;

    assign press_raw = (ACTIVE_LOW != 0) ? btn_negedge : btn_posedge;
    assign rel_raw   = (ACTIVE_LOW != 0) ? btn_posedge : btn_negedge;

    // Coincident press and release are treated as noise: both dropped.
    assign press_e = press_raw & ~rel_raw;
    assign rel_e   = rel_raw & ~press_raw;

    // Release is checked before the timer in every state, so a release (or a
    // GAP press) landing on the expiry cycle takes priority over the timeout.
    always_comb begin
        state_nxt  = state;
        second_nxt = second;
        tap_nxt    = 1'b0;
        dbl_nxt    = 1'b0;
        lp_nxt     = 1'b0;
        rep_nxt    = 1'b0;
        case (state)
            S_IDLE: begin
                if (press_e) begin
                    state_nxt  = S_PRESSED;
                    second_nxt = 1'b0;
                end
            end
            S_PRESSED: begin
                if (rel_e) begin
                    tap_nxt   = 1'b1;
                    dbl_nxt   = second;
                    state_nxt = second ? S_IDLE : S_GAP;
                end else if (ms_cnt == LONG_N) begin
                    lp_nxt     = 1'b1;
                    state_nxt  = S_HELD;
                    second_nxt = 1'b0;
                end
            end
            S_HELD: begin
                if (rel_e) begin
                    state_nxt = S_IDLE;
                end else if ((REPEAT_MS != 0) && (ms_cnt == REPEAT_N)) begin
                    rep_nxt = 1'b1;
                end
            end
            S_GAP: begin
                if (press_e) begin
                    state_nxt  = S_PRESSED;
                    second_nxt = 1'b1;
                end else if (ms_cnt == DOUBLE_N) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Timer restarts on any state change and on each repeat, so repeat
    // spacing is measured from the previous repeat (or the long_press).
    assign restart = (state_nxt != state) | rep_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc  <= '0;
            ms_cnt <= '0;
        end else if (restart) begin
            presc  <= '0;
            ms_cnt <= '0;
        end else if (presc == PRESC_LAST) begin
            presc <= '0;
            if (ms_cnt != MS_MAX)
                ms_cnt <= ms_cnt + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            second     <= 1'b0;
            tap        <= 1'b0;
            double_tap <= 1'b0;
            long_press <= 1'b0;
            repeat_out <= 1'b0;
            pressed    <= 1'b0;
        end else begin
            state      <= state_nxt;
            second     <= second_nxt;
            tap        <= tap_nxt;
            double_tap <= dbl_nxt;
            long_press <= lp_nxt;
            repeat_out <= rep_nxt;
            pressed    <= (state_nxt == S_PRESSED) | (state_nxt == S_HELD);
        end
    end

endmodule
